// File: rtl/memoria_principal_wb.sv
// +--------------------------------------------------------------------------+
// | memoria_principal_wb: 16x8 main memory with latency and write-back FIFO  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module memoria_principal_wb #(
  parameter int LATENCIA  = 3,
  parameter int PROF_WB   = 2,
  parameter int LARG_END  = 4,
  parameter int LARG_DADO = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rd_req,
  input  logic [LARG_END-1:0]  rd_end,
  output logic                 rd_pronto,
  output logic                 rd_valid,
  output logic [LARG_DADO-1:0] rd_dado,
  input  logic                 wb_req,
  input  logic [LARG_END-1:0]  wb_end,
  input  logic [LARG_DADO-1:0] wb_dado,
  output logic                 wb_ack,
  output logic                 wb_cheio,
  output logic                 ocupado
);

  localparam int C_PROF_MEM = 2 ** LARG_END;
  localparam int C_CNT_W    = (LATENCIA > 1) ? $clog2(LATENCIA) : 1;
  localparam int C_OCUP_W   = $clog2(PROF_WB + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_INI = C_CNT_W'(LATENCIA - 1);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    LEITURA  = 2'd1,
    RESPOSTA = 2'd2,
    ESCRITA  = 2'd3
  } estado_t;

  estado_t                estado_q, estado_d;
  logic [C_CNT_W-1:0]     cnt_q, cnt_d;
  logic [LARG_END-1:0]    end_q, end_d;
  logic [LARG_DADO-1:0]   rd_dado_q, rd_dado_d;
  logic [C_OCUP_W-1:0]    ocup_q, ocup_d;
  logic [LARG_END-1:0]    buf_end_q  [PROF_WB];
  logic [LARG_END-1:0]    buf_end_d  [PROF_WB];
  logic [LARG_DADO-1:0]   buf_dado_q [PROF_WB];
  logic [LARG_DADO-1:0]   buf_dado_d [PROF_WB];
  logic [LARG_DADO-1:0]   mem_q      [C_PROF_MEM];
  logic [LARG_DADO-1:0]   mem_d      [C_PROF_MEM];

  logic [PROF_WB-1:0]     wb_hit;
  logic [PROF_WB-1:0]     rd_hit;
  logic [LARG_DADO-1:0]   fwd_dado;
  logic [LARG_DADO-1:0]   head_dado;
  logic                   pop;

  // Address lookup over the occupied buffer entries only
  always_comb begin
    wb_hit   = '0;
    rd_hit   = '0;
    fwd_dado = '0;
    for (int i = 0; i < PROF_WB; i++) begin
      if (C_OCUP_W'(i) < ocup_q) begin
        wb_hit[i] = (buf_end_q[i] == wb_end);
        rd_hit[i] = (buf_end_q[i] == rd_end);
        if (buf_end_q[i] == rd_end) fwd_dado = buf_dado_q[i];
      end
    end
  end

  assign wb_cheio  = (ocup_q == C_OCUP_W'(PROF_WB));
  assign wb_ack    = wb_req & ~(wb_cheio & ~(|wb_hit));
  assign rd_pronto = (estado_q == OCIOSO);
  assign rd_valid  = (estado_q == RESPOSTA);
  assign rd_dado   = rd_dado_q;
  assign ocupado   = (estado_q != OCIOSO) || (ocup_q != '0);
  // A coalesce landing on the head in its pop cycle must not be lost
  assign head_dado = (wb_hit[0] && wb_req) ? wb_dado : buf_dado_q[0];

  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    end_d     = end_q;
    rd_dado_d = rd_dado_q;
    pop       = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (rd_req && (|rd_hit)) begin
          rd_dado_d = fwd_dado;
          estado_d  = RESPOSTA;
        end else if (rd_req) begin
          end_d    = rd_end;
          cnt_d    = C_CNT_INI;
          estado_d = LEITURA;
        end else if (ocup_q != '0) begin
          cnt_d    = C_CNT_INI;
          estado_d = ESCRITA;
        end
      end
      LEITURA: begin
        if (cnt_q == '0) begin
          rd_dado_d = mem_q[end_q];
          estado_d  = RESPOSTA;
        end else begin
          cnt_d = cnt_q - C_CNT_W'(1);
        end
      end
      RESPOSTA: estado_d = OCIOSO;
      ESCRITA: begin
        if (cnt_q == '0) begin
          pop      = 1'b1;
          estado_d = OCIOSO;
        end else begin
          cnt_d = cnt_q - C_CNT_W'(1);
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // Buffer update order: coalesce, then pop (shift), then push at new tail
  always_comb begin
    buf_end_d  = buf_end_q;
    buf_dado_d = buf_dado_q;
    ocup_d     = ocup_q;
    for (int i = 0; i < PROF_WB; i++) begin
      if (wb_hit[i] && wb_ack) buf_dado_d[i] = wb_dado;
    end
    if (pop) begin
      for (int i = 0; i < PROF_WB - 1; i++) begin
        buf_end_d[i]  = buf_end_d[i+1];
        buf_dado_d[i] = buf_dado_d[i+1];
      end
      ocup_d = ocup_d - C_OCUP_W'(1);
    end
    if (wb_ack && !(|wb_hit)) begin
      for (int i = 0; i < PROF_WB; i++) begin
        if (C_OCUP_W'(i) == ocup_d) begin
          buf_end_d[i]  = wb_end;
          buf_dado_d[i] = wb_dado;
        end
      end
      ocup_d = ocup_d + C_OCUP_W'(1);
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (pop) mem_d[buf_end_q[0]] = head_dado;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q  <= OCIOSO;
      cnt_q     <= '0;
      end_q     <= '0;
      rd_dado_q <= '0;
      ocup_q    <= '0;
      for (int i = 0; i < PROF_WB; i++) begin
        buf_end_q[i]  <= '0;
        buf_dado_q[i] <= '0;
      end
      for (int i = 0; i < C_PROF_MEM; i++) begin
        mem_q[i] <= LARG_DADO'(i);
      end
    end else begin
      estado_q   <= estado_d;
      cnt_q      <= cnt_d;
      end_q      <= end_d;
      rd_dado_q  <= rd_dado_d;
      ocup_q     <= ocup_d;
      buf_end_q  <= buf_end_d;
      buf_dado_q <= buf_dado_d;
      mem_q      <= mem_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_memoria_principal_wb.sv
// +--------------------------------------------------------------------------+
// | tb_memoria_principal_wb: directed bench for memoria_principal_wb          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_memoria_principal_wb;

  logic       clock = 1'b0;
  logic       reset;
  logic       rd_req;
  logic [3:0] rd_end;
  logic       rd_pronto;
  logic       rd_valid;
  logic [7:0] rd_dado;
  logic       wb_req;
  logic [3:0] wb_end;
  logic [7:0] wb_dado;
  logic       wb_ack;
  logic       wb_cheio;
  logic       ocupado;

  int checks = 0;
  int errors = 0;

  memoria_principal_wb #(
    .LATENCIA (3),
    .PROF_WB  (2),
    .LARG_END (4),
    .LARG_DADO(8)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .rd_req   (rd_req),
    .rd_end   (rd_end),
    .rd_pronto(rd_pronto),
    .rd_valid (rd_valid),
    .rd_dado  (rd_dado),
    .wb_req   (wb_req),
    .wb_end   (wb_end),
    .wb_dado  (wb_dado),
    .wb_ack   (wb_ack),
    .wb_cheio (wb_cheio),
    .ocupado  (ocupado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue a one-cycle read request and measure cycles until rd_valid
  task automatic do_read(input string tag, input logic [3:0] a,
                         input logic [7:0] exp_d, input int exp_lat);
    int n;
    rd_req = 1'b1;
    rd_end = a;
    tick();
    rd_req = 1'b0;
    n = 1;
    chk({tag, "_pronto"}, 32'(rd_pronto), 32'd0);
    while (!rd_valid && n < 12) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_dado"}, 32'(rd_dado), 32'(exp_d));
    tick();
    chk({tag, "_pulse"}, 32'(rd_valid), 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (ocupado && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(ocupado), 32'd0);
  endtask

  task automatic push(input logic [3:0] a, input logic [7:0] d);
    wb_req  = 1'b1;
    wb_end  = a;
    wb_dado = d;
  endtask

  initial begin
    int seen;
    reset   = 1'b1;
    rd_req  = 1'b0;
    rd_end  = '0;
    wb_req  = 1'b0;
    wb_end  = '0;
    wb_dado = '0;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_valid",  32'(rd_valid),  32'd0);
    chk("rst_dado",   32'(rd_dado),   32'd0);
    chk("rst_cheio",  32'(wb_cheio),  32'd0);
    chk("rst_ocup",   32'(ocupado),   32'd0);
    chk("rst_pronto", 32'(rd_pronto), 32'd1);

    // Plain miss read
    do_read("t1", 4'd5, 8'h05, 4);

    // Buffered write forwarded to a read
    push(4'd3, 8'hAA);
    #1 chk("t2_ack", 32'(wb_ack), 32'd1);
    tick();
    wb_req = 1'b0;
    chk("t2_ocup", 32'(ocupado), 32'd1);
    do_read("t2", 4'd3, 8'hAA, 1);
    wait_idle("t2_idle");
    do_read("t2m", 4'd3, 8'hAA, 4);

    // Fill buffer, reject new address when full, coalesce into existing one
    push(4'd1, 8'h51);
    tick();
    push(4'd2, 8'h52);
    tick();
    chk("t3_cheio", 32'(wb_cheio), 32'd1);
    push(4'd7, 8'h77);
    #1 chk("t3_ack7", 32'(wb_ack), 32'd0);
    tick();
    push(4'd2, 8'hCC);
    #1 chk("t3_ack2", 32'(wb_ack), 32'd1);
    tick();
    wb_req = 1'b0;
    wait_idle("t3_idle");
    chk("t3_cheio0", 32'(wb_cheio), 32'd0);
    do_read("t3m2", 4'd2, 8'hCC, 4);
    do_read("t3m1", 4'd1, 8'h51, 4);
    do_read("t3m7", 4'd7, 8'h07, 4);

    // Read wins over a pending drain
    push(4'd9, 8'h99);
    tick();
    wb_req = 1'b0;
    do_read("t4", 4'd6, 8'h06, 4);
    chk("t4_pronto", 32'(rd_pronto), 32'd1);
    chk("t4_ocup",   32'(ocupado),   32'd1);
    tick();
    chk("t4_drain",  32'(rd_pronto), 32'd0);
    wait_idle("t4_idle");
    do_read("t4m", 4'd9, 8'h99, 4);

    // Hit while a write to the same address coalesces: old data returned
    push(4'hA, 8'h1A);
    tick();
    wb_dado = 8'h2A;
    #1 chk("t7_ack", 32'(wb_ack), 32'd1);
    do_read("t7", 4'hA, 8'h1A, 1);
    wb_req = 1'b0;
    wait_idle("t7_idle");
    do_read("t7m", 4'hA, 8'h2A, 4);

    // Reset during a read miss with a buffered write
    push(4'd8, 8'hE8);
    tick();
    wb_req = 1'b0;
    rd_req = 1'b1;
    rd_end = 4'd0;
    tick();
    rd_req = 1'b0;
    chk("t5_leit", 32'(rd_pronto), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_pronto", 32'(rd_pronto), 32'd1);
    chk("t5_ocup",   32'(ocupado),   32'd0);
    chk("t5_cheio",  32'(wb_cheio),  32'd0);
    chk("t5_dado",   32'(rd_dado),   32'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (rd_valid) seen++;
      tick();
    end
    chk("t5_novalid", seen, 0);
    do_read("t5m8", 4'd8, 8'h08, 4);
    do_read("t5m2", 4'd2, 8'h02, 4);

    // Drained write visible to a later miss
    push(4'd4, 8'h11);
    tick();
    wb_req = 1'b0;
    wait_idle("t6_idle");
    do_read("t6", 4'd4, 8'h11, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
